// File: rtl/popcnt_pattern_gen_pkg.sv
// Shared types and helpers for the constant-popcount word generator.
// Optional self-check is enabled by defining POPCNT_PATTERN_GEN_SELFCHK_EN.
package popcnt_pattern_gen_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    // Helpers work in MAX_W+1 bits so k == 32 still yields a well-formed mask.
    function automatic logic [MAX_W:0] first_word(input logic [5:0] k, input int unsigned w);
        logic [MAX_W:0] ones_k;
        logic [MAX_W:0] ones_w;
        ones_k = (33'd1 << k) - 33'd1;
        ones_w = (33'd1 << w) - 33'd1;
        return ones_k & ones_w;
    endfunction

    function automatic logic [MAX_W:0] last_word(input logic [5:0] k, input int unsigned w);
        return first_word(k, w) << (w - 32'(k));
    endfunction

    function automatic logic [5:0] ctz(input logic [MAX_W:0] x);
        logic [5:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i <= MAX_W; i++) begin
            if (!found && x[i]) begin
                r     = 6'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [5:0] popcount(input logic [MAX_W-1:0] x);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r = r + 6'(x[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/popcnt_pattern_gen_next.sv
// Combinational Gosper step: next larger word with the same number of ones.
module popcnt_pattern_gen_next
    import popcnt_pattern_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] x_i,
    output logic [DATA_WIDTH-1:0] next_o
);

    logic [DATA_WIDTH:0] xe;
    logic [DATA_WIDTH:0] c;
    logic [DATA_WIDTH:0] r;
    logic [DATA_WIDTH:0] t;

    // The divide by the lowest set bit becomes a right shift by its index.
    always_comb begin
        xe     = {1'b0, x_i};
        c      = xe & (-xe);
        r      = xe + c;
        t      = ((r ^ xe) >> 2) >> ctz(33'(c));
        next_o = DATA_WIDTH'(r | t);
    end

endmodule

// File: rtl/popcnt_pattern_gen.sv
// Enumerates every DATA_WIDTH-bit word with exactly k ones over a valid/ready stream.
// Define POPCNT_PATTERN_GEN_SELFCHK_EN to add a popcount self-check with sticky chk_fail.
module popcnt_pattern_gen
    import popcnt_pattern_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    localparam int CNT_WIDTH = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  k,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    output logic                  err
);

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  k_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_q;
    logic                  busy_q;
    logic                  last_q;
    logic                  err_q;
`ifdef POPCNT_PATTERN_GEN_SELFCHK_EN
    logic                  chk_fail_q;
`endif

    logic [MAX_W:0] first_ext;
    logic [MAX_W:0] last_ext;
    logic           k_in_range;
    logic           first_is_last;
    logic           next_is_last;

    popcnt_pattern_gen_next #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_next (
        .x_i   (data_q),
        .next_o(data_d)
    );

    always_comb begin
        first_ext     = first_word(6'(k), DATA_WIDTH);
        last_ext      = last_word(6'(k_q), DATA_WIDTH);
        k_in_range    = 32'(k) <= DATA_WIDTH;
        first_is_last = (k == '0) || (32'(k) == DATA_WIDTH);
        next_is_last  = data_d == DATA_WIDTH'(last_ext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef POPCNT_PATTERN_GEN_SELFCHK_EN
            chk_fail_q <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (k_in_range) begin
                            state_q <= RUN;
                            k_q     <= k;
                            data_q  <= DATA_WIDTH'(first_ext);
                            last_q  <= first_is_last;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (valid_q && out_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            data_q  <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            data_q <= data_d;
                            last_q <= next_is_last;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef POPCNT_PATTERN_GEN_SELFCHK_EN
            if (valid_q && (popcount(32'(data_q)) != 6'(k_q))) begin
                err_q      <= 1'b1;
                chk_fail_q <= 1'b1;
            end
`endif
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign data      = data_q;
    assign last      = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_popcnt_pattern_gen.sv
// Scoreboard bench: directed enumerations on W=4 and W=8 instances, monitor-side checking.
module tb_popcnt_pattern_gen;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n4, rst_n8;
    logic       start4, start8;
    logic [2:0] k4;
    logic [3:0] k8;
    logic       busy4, busy8, valid4, valid8, ready4, ready8;
    logic       last4, last8, err4, err8;
    logic [3:0] data4;
    logic [7:0] data8;

    int total = 0;
    int bad   = 0;
    exp_t q4[$];
    exp_t q8[$];
    int beats4 = 0;
    int seen4[16];

    // Hand-computed enumerations for W=4, grouped by k = 0..4.
    int tbl4[16] = '{0, 1, 2, 4, 8, 3, 5, 6, 9, 10, 12, 7, 11, 13, 14, 15};
    int off4[5]  = '{0, 1, 5, 11, 15};
    int num4[5]  = '{1, 4, 6, 4, 1};

    always #5 clk = ~clk;

    popcnt_pattern_gen #(.DATA_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .start(start4), .k(k4), .busy(busy4),
        .out_valid(valid4), .out_ready(ready4), .data(data4), .last(last4), .err(err4)
    );

    popcnt_pattern_gen #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .start(start8), .k(k8), .busy(busy8),
        .out_valid(valid8), .out_ready(ready8), .data(data8), .last(last8), .err(err8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid4 && ready4) begin
            beats4++;
            seen4[data4]++;
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL beat4_unexpected: got %h expected none", data4);
            end else begin
                e = q4.pop_front();
                check("beat4_data", 32'(data4), 32'(e.d));
                check("beat4_last", 32'(last4), 32'(e.l));
            end
        end
        if (valid8 && ready8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL beat8_unexpected: got %h expected none", data8);
            end else begin
                e = q8.pop_front();
                check("beat8_data", 32'(data8), 32'(e.d));
                check("beat8_last", 32'(last8), 32'(e.l));
            end
        end
    end

    task automatic start_4(input logic [2:0] kk);
        @(negedge clk);
        start4 = 1'b1;
        k4     = kk;
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    task automatic start_8(input logic [3:0] kk);
        @(negedge clk);
        start8 = 1'b1;
        k8     = kk;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Waits until the W=4 stream goes idle; returns cycles spent with valid high.
    task automatic drain_4(output int cycles);
        cycles = 0;
        while (valid4 && cycles < 200) begin
            @(posedge clk);
            #1 cycles++;
        end
        if (cycles >= 200) begin
            total++; bad++;
            $display("FAIL drain4_timeout: got %0d cycles expected < 200", cycles);
        end
    endtask

    task automatic run_4(input int kk);
        int cyc;
        for (int i = 0; i < num4[kk]; i++)
            q4.push_back('{d: 8'(tbl4[off4[kk] + i]), l: (i == num4[kk] - 1)});
        start_4(3'(kk));
        check("first_valid_latency", {30'd0, busy4, valid4}, 32'd3);
        drain_4(cyc);
        check("burst_cycles", 32'(cyc), 32'(num4[kk]));
        check("idle_after_last", {29'd0, busy4, valid4, last4}, 32'd0);
    endtask

    initial begin
        int cyc;
        int once;
        rst_n4 = 1'b0; rst_n8 = 1'b0;
        start4 = 1'b0; start8 = 1'b0;
        k4 = '0; k8 = '0;
        ready4 = 1'b1; ready8 = 1'b1;
        #1;
        check("reset4", {24'd0, busy4, valid4, last4, err4, data4}, 32'd0);
        check("reset8", {20'd0, busy8, valid8, last8, err8, data8}, 32'd0);
        @(negedge clk);
        rst_n4 = 1'b1; rst_n8 = 1'b1;
        repeat (2) @(posedge clk);

        // k = 0..4 sweep: includes k=2 ordering, k=0 and k=4 single beats.
        foreach (seen4[v]) seen4[v] = 0;
        beats4 = 0;
        for (int kk = 0; kk <= 4; kk++) run_4(kk);
        check("sweep_total_beats", 32'(beats4), 32'd16);
        once = 0;
        foreach (seen4[v]) if (seen4[v] == 1) once++;
        check("sweep_cover_once", 32'(once), 32'd16);

        // Out-of-range k.
        start_4(3'd5);
        check("err_pulse", {29'd0, err4, valid4, busy4}, 32'd4);
        @(posedge clk);
        #1 check("err_clears", {29'd0, err4, valid4, busy4}, 32'd0);

        // Backpressure on the second beat of k=1.
        for (int i = 0; i < 4; i++) q4.push_back('{d: 8'(tbl4[1 + i]), l: (i == 3)});
        start_4(3'd1);
        @(posedge clk);
        #1 ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("stall_hold", {26'd0, valid4, last4, data4}, {26'd0, 1'b1, 1'b0, 4'b0010});
        end
        ready4 = 1'b1;
        drain_4(cyc);
        check("q4_empty", 32'(q4.size()), 32'd0);

        // W=8 k=3 with reset after the 5th accepted beat.
        q8.push_back('{d: 8'h07, l: 1'b0});
        q8.push_back('{d: 8'h0B, l: 1'b0});
        q8.push_back('{d: 8'h0D, l: 1'b0});
        q8.push_back('{d: 8'h0E, l: 1'b0});
        q8.push_back('{d: 8'h13, l: 1'b0});
        start_8(4'd3);
        repeat (5) @(posedge clk);
        #1 rst_n8 = 1'b0;
        #1 check("abort_reset8", {20'd0, busy8, valid8, last8, err8, data8}, 32'd0);
        check("q8_empty", 32'(q8.size()), 32'd0);
        @(negedge clk);
        rst_n8 = 1'b1;
        ready8 = 1'b0;
        start_8(4'd3);
        check("restart8_first", {22'd0, busy8, valid8, data8}, {22'd0, 1'b1, 1'b1, 8'h07});
        rst_n8 = 1'b0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
